// File: rtl/usb_pkg.sv
// Shared definitions for the USB device transaction layer.
// Holds handshake PID codes, data PID codes and the sequencer state encoding.
package usb_pkg;

   typedef enum logic [1:0] {
      HsAck   = 2'd0,
      HsNak   = 2'd1,
      HsNyet  = 2'd2,
      HsStall = 2'd3
   } hs_e;

   typedef enum logic [1:0] {
      Data0 = 2'd0,
      Data1 = 2'd1,
      Data2 = 2'd2,
      Mdata = 2'd3
   } data_e;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRxWait   = 3'd1,
      StRxData   = 3'd2,
      StTxHs     = 3'd3,
      StTxData   = 3'd4,
      StTxWaitHs = 3'd5
   } state_e;

endpackage

// File: rtl/usb_ep_toggle.sv
// Per-endpoint DATA0/DATA1 toggle bits for the OUT and IN directions.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_ep_i             endpoint whose toggles are updated
//   out_flip_i          flip the OUT toggle of wr_ep_i
//   in_flip_i           flip the IN toggle of wr_ep_i
//   setup_ack_i         SETUP acknowledged: both toggles of wr_ep_i become 1
//   rd_ep_i             endpoint whose toggles are read
//   out_tog_o, in_tog_o current toggles of rd_ep_i (0 for unimplemented endpoints)
module usb_ep_toggle
   import usb_pkg::*;
#(
   parameter int unsigned NUM_EP = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] wr_ep_i,
   input  logic       out_flip_i,
   input  logic       in_flip_i,
   input  logic       setup_ack_i,
   input  logic [3:0] rd_ep_i,
   output logic       out_tog_o,
   output logic       in_tog_o
);

   logic [NUM_EP-1:0] out_q, out_d, in_q, in_d;
   logic [15:0]       out_ext, in_ext;

   always_comb begin
      out_d = out_q;
      in_d  = in_q;
      for (int i = 0; i < NUM_EP; i++) begin
         if (wr_ep_i == 4'(i)) begin
            if (setup_ack_i) begin
               out_d[i] = 1'b1;
               in_d[i]  = 1'b1;
            end else begin
               if (out_flip_i) out_d[i] = ~out_q[i];
               if (in_flip_i)  in_d[i]  = ~in_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         in_q  <= '0;
      end else begin
         out_q <= out_d;
         in_q  <= in_d;
      end
   end

   // Widen to 16 so any 4-bit endpoint number indexes safely.
   assign out_ext   = 16'(out_q);
   assign in_ext    = 16'(in_q);
   assign out_tog_o = out_ext[rd_ep_i];
   assign in_tog_o  = in_ext[rd_ep_i];

endmodule

// File: rtl/usb_transaction.sv
// Device-side USB transaction sequencer sitting on top of the packet layer.
// Accepts tokens addressed to this device, routes OUT/SETUP payload to the
// application, sources IN payload from it, keeps per-endpoint data toggles and
// generates ACK/NAK/STALL handshakes. Host responses are bounded by TIMEOUT.
// Ports:
//   device_addr_i, ep_*_i          device address and per-endpoint status
//   rx_*_i / rx_data_tready_o      tokens, data and handshakes from the packet layer
//   tx_*_o / tx_ready_i, tx_data_tready_i   handshake/data requests to the packet layer
//   ep_out_*_o / ep_out_tready_i   OUT/SETUP payload towards the application
//   ep_in_*_i / ep_in_tready_o     IN payload from the application
//   ep_in_done_o, ep_in_timeout_o  IN completion / failure pulses
module usb_transaction
   import usb_pkg::*;
#(
   parameter int unsigned NUM_EP  = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        device_addr_i,
   input  logic [NUM_EP-1:0] ep_stall_i,
   input  logic [NUM_EP-1:0] ep_out_ready_i,
   input  logic [NUM_EP-1:0] ep_in_valid_i,
   input  logic [NUM_EP-1:0] ep_in_zlp_i,
   input  logic              rx_out_i,
   input  logic              rx_in_i,
   input  logic              rx_setup_i,
   input  logic [6:0]        rx_addr_i,
   input  logic [3:0]        rx_endpoint_i,
   input  logic              rx_handshake_i,
   input  logic [1:0]        rx_handshake_type_i,
   input  logic              rx_data_i,
   input  logic [1:0]        rx_data_type_i,
   input  logic [7:0]        rx_data_tdata_i,
   input  logic              rx_data_tlast_i,
   input  logic              rx_data_error_i,
   input  logic              rx_data_tvalid_i,
   output logic              rx_data_tready_o,
   input  logic              tx_ready_i,
   output logic              tx_handshake_o,
   output logic [1:0]        tx_handshake_type_o,
   output logic              tx_data_o,
   output logic              tx_data_null_o,
   output logic [1:0]        tx_data_type_o,
   output logic [7:0]        tx_data_tdata_o,
   output logic              tx_data_tlast_o,
   output logic              tx_data_tvalid_o,
   input  logic              tx_data_tready_i,
   output logic [7:0]        ep_out_tdata_o,
   output logic              ep_out_tlast_o,
   output logic              ep_out_tvalid_o,
   output logic              ep_out_error_o,
   output logic              ep_out_setup_o,
   input  logic              ep_out_tready_i,
   output logic [3:0]        ep_out_endpoint_o,
   output logic [3:0]        ep_in_endpoint_o,
   input  logic [7:0]        ep_in_tdata_i,
   input  logic              ep_in_tlast_i,
   input  logic              ep_in_tvalid_i,
   output logic              ep_in_tready_o,
   output logic              ep_in_done_o,
   output logic              ep_in_timeout_o
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   hs_e           hs_q, hs_d;
   logic [3:0]    ep_q, ep_d;
   logic          fwd_q, fwd_d, drop_q, drop_d, setup_q, setup_d;
   logic          pend_q, pend_d, null_q, null_d;
   logic [TW-1:0] tmr_q, tmr_d;

   logic          out_flip, in_flip, setup_ack, out_tog, in_tog, exp_tog;
   logic [3:0]    ep_sel;
   logic [15:0]   stall_ext, ready_ext, valid_ext, zlp_ext;
   logic          stall_sel, ready_sel, valid_sel, zlp_sel;
   logic          tok, tok_ok, tmo, fwd_path;

   // Before a token is latched, endpoint lookups follow the incoming token.
   assign ep_sel    = (state_q == StIdle) ? rx_endpoint_i : ep_q;
   assign stall_ext = 16'(ep_stall_i);
   assign ready_ext = 16'(ep_out_ready_i);
   assign valid_ext = 16'(ep_in_valid_i);
   assign zlp_ext   = 16'(ep_in_zlp_i);
   assign stall_sel = stall_ext[ep_sel];
   assign ready_sel = ready_ext[ep_sel];
   assign valid_sel = valid_ext[ep_sel];
   assign zlp_sel   = zlp_ext[ep_sel];

   assign tok      = rx_out_i | rx_in_i | rx_setup_i;
   assign tok_ok   = tok && (rx_addr_i == device_addr_i) && (32'(rx_endpoint_i) < NUM_EP);
   assign tmo      = (tmr_q == TW'(TIMEOUT));
   // SETUP always starts with DATA0 regardless of the stored toggle.
   assign exp_tog  = setup_q ? 1'b0 : out_tog;
   assign fwd_path = fwd_q & ~drop_q;

   assign ep_out_setup_o    = setup_q;
   assign ep_out_endpoint_o = ep_q;
   assign ep_in_endpoint_o  = ep_q;

   usb_ep_toggle #(
      .NUM_EP (NUM_EP)
   ) u_toggle (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_ep_i     (ep_q),
      .out_flip_i  (out_flip),
      .in_flip_i   (in_flip),
      .setup_ack_i (setup_ack),
      .rd_ep_i     (ep_sel),
      .out_tog_o   (out_tog),
      .in_tog_o    (in_tog)
   );

   always_comb begin
      state_d = state_q;
      hs_d    = hs_q;
      ep_d    = ep_q;
      fwd_d   = fwd_q;
      drop_d  = drop_q;
      setup_d = setup_q;
      pend_d  = pend_q;
      null_d  = null_q;
      tmr_d   = '0;
      out_flip  = 1'b0;
      in_flip   = 1'b0;
      setup_ack = 1'b0;
      rx_data_tready_o    = 1'b0;
      tx_handshake_o      = 1'b0;
      tx_handshake_type_o = hs_q;
      tx_data_o           = 1'b0;
      tx_data_null_o      = 1'b0;
      tx_data_type_o      = 2'b00;
      tx_data_tdata_o     = '0;
      tx_data_tlast_o     = 1'b0;
      tx_data_tvalid_o    = 1'b0;
      ep_out_tdata_o      = '0;
      ep_out_tlast_o      = 1'b0;
      ep_out_tvalid_o     = 1'b0;
      ep_out_error_o      = 1'b0;
      ep_in_tready_o      = 1'b0;
      ep_in_done_o        = 1'b0;
      ep_in_timeout_o     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (tok_ok) begin
               ep_d   = rx_endpoint_i;
               drop_d = 1'b0;
               if (rx_setup_i) begin
                  fwd_d   = 1'b1;
                  setup_d = 1'b1;
                  state_d = StRxWait;
               end else if (rx_out_i) begin
                  fwd_d   = ready_sel & ~stall_sel;
                  setup_d = 1'b0;
                  state_d = StRxWait;
               end else if (stall_sel) begin
                  hs_d    = HsStall;
                  state_d = StTxHs;
               end else if (!valid_sel) begin
                  hs_d    = HsNak;
                  state_d = StTxHs;
               end else begin
                  tx_data_o      = tx_ready_i;
                  tx_data_type_o = {1'b0, in_tog};
                  tx_data_null_o = zlp_sel;
                  null_d         = zlp_sel;
                  // Transmitter busy: keep requesting from StTxData.
                  pend_d         = ~tx_ready_i;
                  state_d        = StTxData;
               end
            end
         end

         StRxWait: begin
            tmr_d = tmo ? tmr_q : tmr_q + TW'(1);
            if (tok) begin
               state_d = StIdle;
            end else if (rx_data_i) begin
               drop_d  = (rx_data_type_i != {1'b0, exp_tog});
               state_d = StRxData;
            end else if (tmo) begin
               state_d = StIdle;
            end
         end

         StRxData: begin
            if (fwd_path) begin
               ep_out_tvalid_o  = rx_data_tvalid_i;
               ep_out_tdata_o   = rx_data_tdata_i;
               ep_out_tlast_o   = rx_data_tlast_i;
               ep_out_error_o   = rx_data_error_i & rx_data_tlast_i;
               rx_data_tready_o = ep_out_tready_i;
            end else begin
               rx_data_tready_o = 1'b1;
            end
            if (rx_data_tvalid_i && rx_data_tready_o && rx_data_tlast_i) begin
               if (rx_data_error_i) begin
                  state_d = StIdle;
               end else begin
                  state_d = StTxHs;
                  if (stall_sel && !setup_q) begin
                     hs_d = HsStall;
                  end else if (!fwd_q) begin
                     hs_d = HsNak;
                  end else begin
                     hs_d      = HsAck;
                     setup_ack = setup_q;
                     // A dropped packet is a host retry: ACK it but keep the toggle.
                     out_flip  = ~setup_q & ~drop_q;
                  end
               end
            end
         end

         StTxHs: begin
            tx_handshake_o = 1'b1;
            if (tx_ready_i) state_d = StIdle;
         end

         StTxData: begin
            if (pend_q) begin
               tx_data_o      = tx_ready_i;
               tx_data_type_o = {1'b0, in_tog};
               tx_data_null_o = null_q;
               if (tx_ready_i) begin
                  pend_d = 1'b0;
                  if (null_q) state_d = StTxWaitHs;
               end
            end else if (null_q) begin
               state_d = StTxWaitHs;
            end else begin
               tx_data_tvalid_o = ep_in_tvalid_i;
               tx_data_tdata_o  = ep_in_tdata_i;
               tx_data_tlast_o  = ep_in_tlast_i;
               ep_in_tready_o   = tx_data_tready_i;
               if (ep_in_tvalid_i && tx_data_tready_i && ep_in_tlast_i) state_d = StTxWaitHs;
            end
         end

         StTxWaitHs: begin
            tmr_d = tmo ? tmr_q : tmr_q + TW'(1);
            if (tok) begin
               ep_in_timeout_o = 1'b1;
               state_d         = StIdle;
            end else if (rx_handshake_i) begin
               if (rx_handshake_type_i == HsAck) begin
                  in_flip      = 1'b1;
                  ep_in_done_o = 1'b1;
               end else begin
                  ep_in_timeout_o = 1'b1;
               end
               state_d = StIdle;
            end else if (tmo) begin
               ep_in_timeout_o = 1'b1;
               state_d         = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         hs_q    <= HsAck;
         ep_q    <= '0;
         fwd_q   <= 1'b0;
         drop_q  <= 1'b0;
         setup_q <= 1'b0;
         pend_q  <= 1'b0;
         null_q  <= 1'b0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         hs_q    <= hs_d;
         ep_q    <= ep_d;
         fwd_q   <= fwd_d;
         drop_q  <= drop_d;
         setup_q <= setup_d;
         pend_q  <= pend_d;
         null_q  <= null_d;
         tmr_q   <= tmr_d;
      end
   end

endmodule
